// File: rtl/fifo_rd_packer.sv
// Read-side packer for the async FIFO: pops DATASIZE-bit entries and packs LANES of them
// little-endian into one word, with a flush path that emits a partial word and keep mask.
module fifo_rd_packer #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned LANES    = 4
) (
  input  logic                      rclk,
  input  logic                      rrst,
  input  logic [DATASIZE-1:0]       rdata,
  input  logic                      rempty,
  output logic                      rinc,
  input  logic                      flush,
  output logic [DATASIZE*LANES-1:0] out_data,
  output logic [LANES-1:0]          out_keep,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               word_cnt
);

  localparam int unsigned CntW  = $clog2(LANES);
  localparam int unsigned WordW = DATASIZE * LANES;
  localparam logic [CntW-1:0] LastLane = CntW'(LANES - 1);

  logic [WordW-1:0] acc_q, acc_d, acc_wr;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             flush_pend_q, flush_pend_d;
  logic [WordW-1:0] data_q, data_d;
  logic [LANES-1:0] keep_q, keep_d;
  logic             valid_q, valid_d;
  logic [15:0]      word_cnt_q, word_cnt_d;
  logic             slot_free;
  logic             accept;

  assign accept    = valid_q & out_ready;
  assign slot_free = !valid_q | out_ready;

  // The last lane may only be popped when the completed word has somewhere to go.
  assign rinc = !rrst & !rempty & !flush_pend_q & ((cnt_q != LastLane) | slot_free);

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    data_d       = data_q;
    keep_d       = keep_q;
    valid_d      = valid_q;
    word_cnt_d   = word_cnt_q + 16'(accept);

    acc_wr = acc_q;
    acc_wr[cnt_q*DATASIZE +: DATASIZE] = rdata;

    if (accept) begin
      valid_d = 1'b0;
    end

    if (rinc) begin
      if (cnt_q == LastLane) begin
        data_d  = acc_wr;
        keep_d  = '1;
        valid_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d = acc_wr;
        cnt_d = cnt_q + CntW'(1);
      end
    end

    // Popping is blocked while pending, so the flush never races a pop.
    if (flush_pend_q) begin
      if (slot_free) begin
        flush_pend_d = 1'b0;
        if (cnt_q != '0) begin
          data_d  = acc_q;
          keep_d  = LANES'((32'd1 << cnt_q) - 32'd1);
          valid_d = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
    end else if (flush) begin
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      data_q       <= '0;
      keep_q       <= '0;
      valid_q      <= 1'b0;
      word_cnt_q   <= '0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      valid_q      <= valid_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign out_valid = valid_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a first-word-fall-through FIFO model and a log of
// every word accepted downstream.
module tb_fifo_rd_packer;

  logic        rclk = 1'b0;
  logic        wclk = 1'b0;
  logic        rrst;
  logic [7:0]  rdata;
  logic        rempty;
  logic        rinc;
  logic        flush;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] word_cnt;

  fifo_rd_packer #(.DATASIZE(8), .LANES(4)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rdata     (rdata),
    .rempty    (rempty),
    .rinc      (rinc),
    .flush     (flush),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .word_cnt  (word_cnt)
  );

  // rclk posedges at 70k+35, wclk posedges at 20m+13: the two never coincide.
  initial forever #35 rclk = ~rclk;
  initial begin
    #3;
    forever #10 wclk = ~wclk;
  end

  logic [7:0] mem [0:255];
  logic [7:0] wptr = 8'd0;
  logic [7:0] rptr = 8'd0;
  assign rempty = (wptr == rptr);
  assign rdata  = mem[rptr];

  int pops = 0;
  int bad_pops = 0;
  logic [31:0] log_data [$];
  logic [3:0]  log_keep [$];

  always @(posedge rclk) begin
    if (rinc) begin
      rptr <= rptr + 8'd1;
      pops <= pops + 1;
      if (rempty) bad_pops <= bad_pops + 1;
    end
    if (!rrst && out_valid && out_ready) begin
      log_data.push_back(out_data);
      log_keep.push_back(out_keep);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge rclk);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wptr] = b;
    wptr = wptr + 8'd1;
  endtask

  int p0;
  int base;
  logic [7:0]  rb [0:39];
  logic [31:0] exp_w;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rrst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    tick(2);

    // Reset state, with data already waiting in the FIFO.
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", out_data, 32'h0);
    check("rst_keep", 32'(out_keep), 32'h0);
    check("rst_wcnt", 32'(word_cnt), 32'h0);
    push(8'h11);
    #1;
    check("rst_rinc", 32'(rinc), 32'h0);

    // One full word.
    push(8'h22); push(8'h33); push(8'h44);
    rrst = 1'b0;
    out_ready = 1'b1;
    tick(8);
    check("w1_data", log_data[0], 32'h44332211);
    check("w1_keep", 32'(log_keep[0]), 32'hf);
    check("w1_wcnt", 32'(word_cnt), 32'd1);
    check("w1_pops", 32'(pops), 32'd4);

    // Backpressure: word held, packer fills to three lanes then stalls.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    tick(12);
    check("bp_pops", 32'(pops), 32'd11);
    check("bp_valid", 32'(out_valid), 32'h1);
    check("bp_data", out_data, 32'h04030201);
    check("bp_rinc", 32'(rinc), 32'h0);
    tick(3);
    check("bp_stable", out_data, 32'h04030201);
    out_ready = 1'b1;
    #1;
    check("bp_resume_rinc", 32'(rinc), 32'h1);
    tick(1);
    check("b2b_valid", 32'(out_valid), 32'h1);
    check("b2b_data", out_data, 32'h08070605);
    check("b2b_wcnt", 32'(word_cnt), 32'd2);
    tick(1);
    check("b2b_w0", log_data[1], 32'h04030201);
    check("bp_wcnt", 32'(word_cnt), 32'd3);

    // Partial flush of two entries.
    push(8'hA1); push(8'hB2);
    tick(3);
    check("fl_idle", 32'(out_valid), 32'h0);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(1);
    check("fl_valid", 32'(out_valid), 32'h1);
    check("fl_data", out_data, 32'h0000B2A1);
    check("fl_keep", 32'(out_keep), 32'h3);
    push(8'hC3); push(8'hD4); push(8'hE5); push(8'hF6);
    tick(8);
    check("fl_next_data", log_data[log_data.size()-1], 32'hF6E5D4C3);
    check("fl_next_keep", 32'(log_keep[log_keep.size()-1]), 32'hf);
    check("fl_wcnt", 32'(word_cnt), 32'd5);

    // Flush with nothing accumulated: blocks popping for exactly one cycle, emits nothing.
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    push(8'h10);
    #1;
    check("fe_pend_rinc", 32'(rinc), 32'h0);
    tick(1);
    check("fe_clear_rinc", 32'(rinc), 32'h1);
    check("fe_valid", 32'(out_valid), 32'h0);

    // Reset mid-word with a full word pending downstream.
    out_ready = 1'b0;
    push(8'h20); push(8'h30); push(8'h40); push(8'h50); push(8'h60); push(8'h70);
    tick(10);
    check("mr_valid", 32'(out_valid), 32'h1);
    check("mr_data", out_data, 32'h40302010);
    p0 = pops;
    rrst = 1'b1;
    push(8'h81); push(8'h82); push(8'h83); push(8'h84);
    #1;
    check("mr_rinc", 32'(rinc), 32'h0);
    tick(1);
    check("mr_rst_valid", 32'(out_valid), 32'h0);
    check("mr_rst_data", out_data, 32'h0);
    check("mr_rst_keep", 32'(out_keep), 32'h0);
    check("mr_rst_wcnt", 32'(word_cnt), 32'h0);
    check("mr_rst_pops", 32'(pops), 32'(p0));
    rrst = 1'b0;
    out_ready = 1'b1;
    tick(8);
    check("mr_clean_data", log_data[log_data.size()-1], 32'h84838281);
    check("mr_clean_keep", 32'(log_keep[log_keep.size()-1]), 32'hf);
    check("mr_clean_wcnt", 32'(word_cnt), 32'd1);

    // Random: writer on wclk, random out_ready on rclk.
    rrst = 1'b1;
    tick(1);
    rrst = 1'b0;
    base = log_data.size();
    for (int i = 0; i < 40; i++) rb[i] = 8'(i * 37 + 5);
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge wclk);
          push(rb[i]);
        end
      end
      begin
        for (int c = 0; c < 3000 && word_cnt != 16'd10; c++) begin
          @(negedge rclk);
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    tick(2);
    check("rnd_wcnt", 32'(word_cnt), 32'd10);
    check("rnd_bad_pops", 32'(bad_pops), 32'd0);
    check("rnd_nwords", 32'(log_data.size() - base), 32'd10);
    for (int j = 0; j < 10; j++) begin
      exp_w = {rb[4*j+3], rb[4*j+2], rb[4*j+1], rb[4*j]};
      if (base + j < log_data.size()) begin
        check($sformatf("rnd_word%0d", j), log_data[base+j], exp_w);
        check($sformatf("rnd_keep%0d", j), 32'(log_keep[base+j]), 32'hf);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
